// File: rtl/sc_pkg.sv
// rtl/sc_pkg.sv - shared constants and helpers for the match serializer
// Purpose: default widths, drop counter width, index-width helper and the
//          FIFO word layout {slot, dt} used by the serializer and its FIFO.
// Ports:   none (package).
package sc_pkg;

    localparam int SC_TIME_W  = 16;
    localparam int SC_DROP_W  = 8;
    localparam int SC_N_SLOTS = 37;

    // Index width for n entries; never below 1 so single-entry builds still elaborate.
    function automatic int sc_clog2(input int n);
        int r;
        int v;
        r = 0;
        v = 1;
        while (v < n) begin
            v = v * 2;
            r = r + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

    // FIFO word = {slot index, dt}; slot in the upper bits.
    function automatic int sc_word_w(input int slot_w, input int time_w);
        return slot_w + time_w;
    endfunction

    localparam int SC_WORD_W = sc_word_w(sc_clog2(SC_N_SLOTS), SC_TIME_W);

endpackage

// File: rtl/sc_event_fifo.sv
// rtl/sc_event_fifo.sv - first-word-fall-through event FIFO
// Purpose: DEPTH x WIDTH FWFT FIFO; read data holds the last popped word when empty.
// Ports:   i_clk, i_rst (async, active high), i_push/i_wdata, i_pop,
//          o_rdata (head word, or last popped word when empty), o_full, o_empty.
module sc_event_fifo
    import sc_pkg::*;
#(
    parameter int WIDTH = SC_WORD_W,
    parameter int DEPTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = sc_clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic [WIDTH-1:0] r_hold;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_do_pop  = i_pop && !o_empty;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign w_do_push = i_push && (!o_full || w_do_pop);

    // The storage array is never read while empty, so it needs no reset.
    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_hold   <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
                r_hold   <= r_mem[r_rd_ptr[AW-1:0]];
            end
        end
    end

    assign o_rdata = o_empty ? r_hold : r_mem[r_rd_ptr[AW-1:0]];

endmodule

// File: rtl/sc_match_serializer.sv
// rtl/sc_match_serializer.sv - per-slot match capture and round-robin serializer
// Purpose: captures dt = song_time - note_time per triggered slot, holds events
//          pending, and serialises them round-robin into an FWFT output FIFO.
// Ports:   i_clk, i_rst (async, active high), i_song_time, i_match_trigger[N_SLOTS],
//          i_match_time[N_SLOTS*TIME_W], i_match_ready; o_match_en, o_match_dt,
//          o_match_slot, o_drop_cnt (saturating lost-event count), o_busy.
module sc_match_serializer
    import sc_pkg::*;
#(
    parameter int  N_SLOTS = 37,
    parameter int  TIME_W  = SC_TIME_W,
    parameter int  DEPTH   = 4,
    localparam int SLOT_W  = sc_clog2(N_SLOTS)
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic [TIME_W-1:0]           i_song_time,
    input  logic [N_SLOTS-1:0]          i_match_trigger,
    input  logic [N_SLOTS*TIME_W-1:0]   i_match_time,
    output logic                        o_match_en,
    input  logic                        i_match_ready,
    output logic [TIME_W-1:0]           o_match_dt,
    output logic [SLOT_W-1:0]           o_match_slot,
    output logic [SC_DROP_W-1:0]        o_drop_cnt,
    output logic                        o_busy
);

    localparam int          WORD_W   = sc_word_w(SLOT_W, TIME_W);
    localparam logic [31:0] DROP_MAX = (32'd1 << SC_DROP_W) - 32'd1;

    logic [N_SLOTS-1:0]   r_pending;
    logic [TIME_W-1:0]    r_dt [N_SLOTS];
    logic [SLOT_W-1:0]    r_rr_ptr;
    logic [SC_DROP_W-1:0] r_drop_cnt;

    logic                 w_found;
    logic [SLOT_W-1:0]    w_sel;
    logic [SLOT_W-1:0]    w_next_ptr;
    logic                 w_grant;
    logic                 w_pop;
    logic                 w_full;
    logic                 w_empty;
    logic [31:0]          w_retrig;
    logic [31:0]          w_drop_sum;
    logic [SC_DROP_W-1:0] w_drop_next;
    logic [WORD_W-1:0]    w_rdata;

    // Round-robin search: first pending slot at or after r_rr_ptr, wrapping.
    always_comb begin
        logic [SLOT_W:0] w_cand;
        w_found = 1'b0;
        w_sel   = '0;
        w_cand  = '0;
        for (int j = 0; j < N_SLOTS; j++) begin
            w_cand = {1'b0, r_rr_ptr} + (SLOT_W+1)'(j);
            if (w_cand >= (SLOT_W+1)'(N_SLOTS)) begin
                w_cand = w_cand - (SLOT_W+1)'(N_SLOTS);
            end
            if (!w_found && r_pending[w_cand[SLOT_W-1:0]]) begin
                w_found = 1'b1;
                w_sel   = w_cand[SLOT_W-1:0];
            end
        end
    end

    assign w_pop      = !w_empty && i_match_ready;
    assign w_grant    = w_found && (!w_full || w_pop);
    assign w_next_ptr = (w_sel == SLOT_W'(N_SLOTS-1)) ? '0 : w_sel + SLOT_W'(1);

    // A retrigger loses the old value only if that value is not leaving this cycle.
    always_comb begin
        w_retrig = '0;
        for (int i = 0; i < N_SLOTS; i++) begin
            if (i_match_trigger[i] && r_pending[i] && !(w_grant && w_sel == SLOT_W'(i))) begin
                w_retrig = w_retrig + 32'd1;
            end
        end
        w_drop_sum  = 32'(r_drop_cnt) + w_retrig;
        w_drop_next = (w_drop_sum > DROP_MAX) ? DROP_MAX[SC_DROP_W-1:0] : w_drop_sum[SC_DROP_W-1:0];
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_pending  <= '0;
            r_rr_ptr   <= '0;
            r_drop_cnt <= '0;
            for (int i = 0; i < N_SLOTS; i++) begin
                r_dt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_SLOTS; i++) begin
                // A new trigger wins over the grant: the old dt is already on its way to the FIFO.
                if (i_match_trigger[i]) begin
                    r_dt[i]      <= i_song_time - i_match_time[i*TIME_W +: TIME_W];
                    r_pending[i] <= 1'b1;
                end else if (w_grant && w_sel == SLOT_W'(i)) begin
                    r_pending[i] <= 1'b0;
                end
            end
            if (w_grant) begin
                r_rr_ptr <= w_next_ptr;
            end
            r_drop_cnt <= w_drop_next;
        end
    end

    sc_event_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (w_grant),
        .i_wdata ({w_sel, r_dt[w_sel]}),
        .i_pop   (w_pop),
        .o_rdata (w_rdata),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign o_match_en                 = !w_empty;
    assign {o_match_slot, o_match_dt} = w_rdata;
    assign o_drop_cnt                 = r_drop_cnt;
    assign o_busy                     = (|r_pending) || !w_empty;

endmodule
